// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: performs a WIDTH-bit add through one N-bit ripple-carry slice,
// one slice per clock with the carry held in a flop between slices.
// Optional feature macro: ADDSEQ_SUB_EN (adds the Sub port for X - Y).
module add_seq_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 4
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
`ifdef ADDSEQ_SUB_EN
   input  logic             Sub,
`endif
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Cout,
   output logic             Overflow
);

   localparam int unsigned SLICES = WIDTH / N;
   localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

   // Reject configurations the slice datapath cannot implement.
   generate
      if ((N == 0) || (WIDTH < N) || ((WIDTH % N) != 0)) begin : g_bad_cfg
         $error("add_seq_ctrl: WIDTH must be a non-zero multiple of N");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   x_sh_q, x_sh_d;
   logic [WIDTH-1:0]   y_sh_q, y_sh_d;
   logic               xmsb_q, xmsb_d;
   logic               ymsb_q, ymsb_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic               start_acc;
   logic               last_slice;
   logic [N-1:0]       slice_s;
   logic [N:0]         rc;
   logic               slice_co;
   logic [WIDTH-1:0]   result_shifted;

   assign start_acc  = (state_q == S_IDLE) && Start;
   assign last_slice = (cnt_q == CNT_W'(SLICES - 1));

   // N-bit ripple-carry slice fed by the low bits of the shift registers.
   assign rc[0] = carry_q;
   generate
      for (genvar gi = 0; gi < int'(N); gi++) begin : g_rca
         assign slice_s[gi] = x_sh_q[gi] ^ y_sh_q[gi] ^ rc[gi];
         assign rc[gi+1]    = (x_sh_q[gi] & y_sh_q[gi]) |
                              (rc[gi] & (x_sh_q[gi] ^ y_sh_q[gi]));
      end
   endgenerate
   assign slice_co = rc[N];

   // Slice sum enters the result from the top so the LSB slice ends up lowest.
   generate
      if (WIDTH == N) begin : g_res_single
         assign result_shifted = slice_s;
      end else begin : g_res_shift
         assign result_shifted = {slice_s, result_q[WIDTH-1:N]};
      end
   endgenerate

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         x_sh_q   <= '0;
         y_sh_q   <= '0;
         xmsb_q   <= 1'b0;
         ymsb_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         x_sh_q   <= x_sh_d;
         y_sh_q   <= y_sh_d;
         xmsb_q   <= xmsb_d;
         ymsb_q   <= ymsb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   // Next-state logic: IDLE -> RUN for SLICES cycles -> DONE for one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start) state_d = S_RUN;
         S_RUN:   if (last_slice) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values; everything holds unless updated below.
   always_comb begin
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      x_sh_d   = x_sh_q;
      y_sh_d   = y_sh_q;
      xmsb_d   = xmsb_q;
      ymsb_d   = ymsb_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start_acc) begin
               x_sh_d = X;
               xmsb_d = X[WIDTH-1];
               cnt_d  = '0;
               busy_d = 1'b1;
`ifdef ADDSEQ_SUB_EN
               y_sh_d  = Sub ? ~Y : Y;
               carry_d = Sub;
               ymsb_d  = Sub ? ~Y[WIDTH-1] : Y[WIDTH-1];
`else
               y_sh_d  = Y;
               carry_d = 1'b0;
               ymsb_d  = Y[WIDTH-1];
`endif
            end
         end
         S_RUN: begin
            result_d = result_shifted;
            x_sh_d   = x_sh_q >> N;
            y_sh_d   = y_sh_q >> N;
            carry_d  = slice_co;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_slice) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               cout_d = slice_co;
               ovf_d  = (xmsb_q == ymsb_q) & (slice_s[N-1] != xmsb_q);
            end
         end
         S_DONE: begin
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Result   = result_q;
   assign Cout     = cout_q;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WIDTH=16, N=4); define ADDSEQ_SUB_EN to
// also exercise subtraction.
`timescale 1ns/1ps
module tb_add_seq_ctrl;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned N     = 4;

   logic             Clock;
   logic             Resetn;
   logic             Start;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             Sub;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Result;
   logic             Cout;
   logic             Overflow;

   int checks = 0;
   int errors = 0;

   add_seq_ctrl #(.WIDTH(WIDTH), .N(N)) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Start    (Start),
      .X        (X),
      .Y        (Y),
`ifdef ADDSEQ_SUB_EN
      .Sub      (Sub),
`endif
      .Busy     (Busy),
      .Done     (Done),
      .Result   (Result),
      .Cout     (Cout),
      .Overflow (Overflow)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Advance one rising edge and settle before sampling or driving.
   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Launch one operation and wait (bounded) for Done; reports Busy cycles seen.
   task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] yb,
                        input logic sb, output int busy_cycles, output bit got_done);
      busy_cycles = 0;
      got_done    = 1'b0;
      X     = xa;
      Y     = yb;
      Sub   = sb;
      Start = 1'b1;
      step();
      Start = 1'b0;
      X     = $urandom();
      Y     = $urandom();
      if (Busy) busy_cycles++;
      for (int i = 0; i < 12; i++) begin
         step();
         if (Done) begin
            got_done = 1'b1;
            break;
         end
         if (Busy) busy_cycles++;
      end
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         Start = 1'($urandom());
         X     = $urandom();
         Y     = $urandom();
         Sub   = 1'($urandom());
         step();
      end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
      checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", Result); end
      checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", Cout); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", Overflow); end
      Start  = 1'b0;
      Sub    = 1'b0;
      Resetn = 1'b1;
      step();
   endtask

   task automatic test_basic_add();
      int bc; bit gd;
      do_op(16'h1234, 16'h4321, 1'b0, bc, gd);
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL basic_done_seen got %b want 1", gd); end
      checks++; if (bc != 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", Busy); end
      checks++; if (Result !== 16'h5555) begin errors++; $display("FAIL basic_result got %h want 5555", Result); end
      checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL basic_cout got %b want 0", Cout); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", Overflow); end
      step();
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", Done); end
      step();
      checks++; if (Result !== 16'h5555) begin errors++; $display("FAIL basic_result_hold got %h want 5555", Result); end
   endtask

   task automatic test_carry_chain();
      int bc; bit gd;
      do_op(16'hFFFF, 16'h0001, 1'b0, bc, gd);
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL chain_done_seen got %b want 1", gd); end
      checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL chain_result got %h want 0000", Result); end
      checks++; if (Cout !== 1'b1) begin errors++; $display("FAIL chain_cout got %b want 1", Cout); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL chain_ovf got %b want 0", Overflow); end
      step();
   endtask

   task automatic test_overflow();
      int bc; bit gd;
      do_op(16'h7FFF, 16'h0001, 1'b0, bc, gd);
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL ovfpos_done_seen got %b want 1", gd); end
      checks++; if (Result !== 16'h8000) begin errors++; $display("FAIL ovfpos_result got %h want 8000", Result); end
      checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL ovfpos_cout got %b want 0", Cout); end
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovfpos_ovf got %b want 1", Overflow); end
      step();
      do_op(16'h8000, 16'h8000, 1'b0, bc, gd);
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL ovfneg_done_seen got %b want 1", gd); end
      checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL ovfneg_result got %h want 0000", Result); end
      checks++; if (Cout !== 1'b1) begin errors++; $display("FAIL ovfneg_cout got %b want 1", Cout); end
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovfneg_ovf got %b want 1", Overflow); end
      step();
   endtask

   task automatic test_start_held();
      int dones;
      int bc; bit gd;
      dones = 0;
      X = 16'h0001; Y = 16'h0001; Sub = 1'b0; Start = 1'b1;
      step();                                    // E0: accepted
      X = 16'hAAAA;
      for (int i = 0; i < 4; i++) begin          // E1..E4 with Start still high
         step();
         if (Done) dones++;
      end
      checks++; if (dones != 1) begin errors++; $display("FAIL held_done_count got %0d want 1", dones); end
      checks++; if (Result !== 16'h0002) begin errors++; $display("FAIL held_result got %h want 0002", Result); end
      step();                                    // E5: DONE -> IDLE, Start ignored
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL held_no_accept_in_done got %b want 0", Busy); end
      step();                                    // E6: first IDLE edge accepts
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL held_accept_after_done got %b want 1", Busy); end
      Start = 1'b0;
      gd = 1'b0;
      bc = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (Done) begin gd = 1'b1; break; end
         bc++;
      end
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL held_second_done got %b want 1", gd); end
      checks++; if (Result !== 16'hAAAB) begin errors++; $display("FAIL held_second_result got %h want aaab", Result); end
      step();
   endtask

   task automatic test_reset_mid_run();
      int dones;
      dones = 0;
      X = 16'h1234; Y = 16'h4321; Sub = 1'b0; Start = 1'b1;
      step();                                    // E0
      Start = 1'b0;
      step();                                    // E1: first RUN edge
      Resetn = 1'b0;
      step();                                    // E2: reset wins
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", Done); end
      checks++; if (Result !== 16'h0000) begin errors++; $display("FAIL midrst_result got %h want 0000", Result); end
      checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b want 0", Cout); end
      Resetn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (Done) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got %b want 0", Busy); end
   endtask

`ifdef ADDSEQ_SUB_EN
   task automatic test_sub();
      int bc; bit gd;
      do_op(16'h0005, 16'h0007, 1'b1, bc, gd);
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL sub1_done_seen got %b want 1", gd); end
      checks++; if (Result !== 16'hFFFE) begin errors++; $display("FAIL sub1_result got %h want fffe", Result); end
      checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL sub1_cout got %b want 0", Cout); end
      checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL sub1_ovf got %b want 0", Overflow); end
      step();
      do_op(16'h8000, 16'h0001, 1'b1, bc, gd);
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL sub2_done_seen got %b want 1", gd); end
      checks++; if (Result !== 16'h7FFF) begin errors++; $display("FAIL sub2_result got %h want 7fff", Result); end
      checks++; if (Cout !== 1'b1) begin errors++; $display("FAIL sub2_cout got %b want 1", Cout); end
      checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL sub2_ovf got %b want 1", Overflow); end
      step();
   endtask
`endif

   initial begin
      Resetn = 1'b0;
      Start  = 1'b0;
      X      = '0;
      Y      = '0;
      Sub    = 1'b0;
      #2;
      test_reset();
      test_basic_add();
      test_carry_chain();
      test_overflow();
      test_start_held();
      test_reset_mid_run();
`ifdef ADDSEQ_SUB_EN
      test_sub();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
